// File: rtl/blake2b_msg_buf_pkg.sv
// blake2b_msg_buf_pkg: shared widths and reset level for the BLAKE2b message buffer
package blake2b_msg_buf_pkg;
    localparam int WORD_WIDTH   = 64;
    localparam int MINDEX_WIDTH = 4;
    localparam int NUM_RD       = 8;
    localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/blake2b_msg_bank.sv
// blake2b_msg_bank: 16-word register file, one sync write port, NUM_RD combinational read ports
module blake2b_msg_bank
    import blake2b_msg_buf_pkg::*;
#(
    parameter int WORD_WIDTH   = blake2b_msg_buf_pkg::WORD_WIDTH,
    parameter int MINDEX_WIDTH = blake2b_msg_buf_pkg::MINDEX_WIDTH,
    parameter int NUM_RD       = blake2b_msg_buf_pkg::NUM_RD
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           we,
    input  logic [MINDEX_WIDTH-1:0]        waddr,
    input  logic [WORD_WIDTH-1:0]          wdata,
    input  logic [NUM_RD*MINDEX_WIDTH-1:0] raddr,
    output logic [NUM_RD*WORD_WIDTH-1:0]   rdata
);
    localparam int DEPTH = 1 << MINDEX_WIDTH;
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        assign rdata[j*WORD_WIDTH +: WORD_WIDTH] = mem[raddr[j*MINDEX_WIDTH +: MINDEX_WIDTH]];
    end
endmodule

// File: rtl/blake2b_msg_buf.sv
// blake2b_msg_buf: double-buffered message store serving index lookups to the G-function array
module blake2b_msg_buf
    import blake2b_msg_buf_pkg::*;
#(
    parameter int WORD_WIDTH   = blake2b_msg_buf_pkg::WORD_WIDTH,
    parameter int MINDEX_WIDTH = blake2b_msg_buf_pkg::MINDEX_WIDTH,
    parameter int NUM_RD       = blake2b_msg_buf_pkg::NUM_RD
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           m_valid_i,
    output logic                           m_ready_o,
    input  logic [WORD_WIDTH-1:0]          m_data_i,
    input  logic                           m_last_i,
    output logic                           blk_valid_o,
    input  logic                           blk_start_i,
    input  logic                           blk_done_i,
    output logic                           blk_last_o,
    input  logic [NUM_RD*MINDEX_WIDTH-1:0] mindex_bus_i,
    output logic [NUM_RD*WORD_WIDTH-1:0]   m_bus_o
);
    logic                          wr_bank, rd_bank, busy;
    logic [1:0]                    full, last;
    logic [MINDEX_WIDTH-1:0]       wcnt;
    logic [NUM_RD*WORD_WIDTH-1:0]  rd_word [2];
    logic                          accept, blk_end, start_ok, done_ok;
    assign m_ready_o   = !full[wr_bank];
    assign blk_valid_o = full[rd_bank] & !busy;
    assign blk_last_o  = last[rd_bank];
    assign accept      = m_valid_i & m_ready_o;
    assign blk_end     = accept & (wcnt == '1);
    assign start_ok    = blk_start_i & blk_valid_o;
    assign done_ok     = blk_done_i & busy;
    assign m_bus_o     = rd_word[rd_bank];
    for (genvar b = 0; b < 2; b++) begin : g_bank
        blake2b_msg_bank #(
            .WORD_WIDTH(WORD_WIDTH), .MINDEX_WIDTH(MINDEX_WIDTH), .NUM_RD(NUM_RD)
        ) u_bank (
            .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
            .we(accept && wr_bank == 1'(b)), .waddr(wcnt), .wdata(m_data_i),
            .raddr(mindex_bus_i), .rdata(rd_word[b])
        );
    end
    // A load can only target an empty bank and done only a full one, so the two full bits never collide
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            busy    <= 1'b0;
            full    <= '0;
            last    <= '0;
            wcnt    <= '0;
        end else if (flush_i) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            busy    <= 1'b0;
            full    <= '0;
            last    <= '0;
            wcnt    <= '0;
        end else begin
            if (accept) wcnt <= wcnt + 1'b1;
            if (blk_end) begin
                full[wr_bank] <= 1'b1;
                last[wr_bank] <= m_last_i;
                wr_bank       <= !wr_bank;
            end
            if (done_ok) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
            busy <= (busy & !done_ok) | start_ok;
        end
    end
endmodule

// File: tb/tb_blake2b_msg_buf.sv
// tb_blake2b_msg_buf: directed corner sequences, lookup vector table and randomized queue-model check
module tb_blake2b_msg_buf;
    localparam int W = 64, MW = 4, NR = 8, BW = NR*W, IW = NR*MW, BLK = 16*W;

    logic clk = 0, rst_i = 1, flush_i = 0, m_valid_i = 0, m_last_i = 0;
    logic blk_start_i = 0, blk_done_i = 0;
    logic m_ready_o, blk_valid_o, blk_last_o;
    logic [W-1:0]  m_data_i = '0;
    logic [IW-1:0] mindex_bus_i = '0;
    logic [BW-1:0] m_bus_o;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    blake2b_msg_buf dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready_o), .m_data_i(m_data_i), .m_last_i(m_last_i),
        .blk_valid_o(blk_valid_o), .blk_start_i(blk_start_i), .blk_done_i(blk_done_i),
        .blk_last_o(blk_last_o), .mindex_bus_i(mindex_bus_i), .m_bus_o(m_bus_o)
    );

    typedef struct { logic [IW-1:0] idx; logic [BW-1:0] exp; } vec_t;
    vec_t vecs[6];

    task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    function automatic logic [BLK-1:0] seq_blk(logic [W-1:0] base);
        logic [BLK-1:0] r;
        for (int i = 0; i < 16; i++) r[i*W +: W] = base + W'(i);
        return r;
    endfunction

    function automatic logic [BW-1:0] lookup(logic [BLK-1:0] blk, logic [IW-1:0] idx);
        logic [BW-1:0] r;
        for (int j = 0; j < NR; j++) r[j*W +: W] = blk[int'(idx[j*MW +: MW])*W +: W];
        return r;
    endfunction

    task automatic word(logic [W-1:0] d, logic l);
        int n = 0;
        m_valid_i = 1; m_data_i = d; m_last_i = l;
        while (!m_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!m_ready_o) chk1("load_timeout", m_ready_o, 1'b1);
        @(negedge clk);
        m_valid_i = 0; m_last_i = 0;
    endtask

    task automatic load_words(logic [W-1:0] base, logic l, int n);
        for (int i = 0; i < n; i++) word(base + W'(i), l && i == 15);
    endtask

    task automatic pulse_start();
        blk_start_i = 1; @(negedge clk); blk_start_i = 0;
    endtask

    task automatic pulse_done();
        blk_done_i = 1; @(negedge clk); blk_done_i = 0;
    endtask

    logic [BLK-1:0] qw[$];
    bit             ql[$];
    logic [W-1:0]   part[$];
    bit             mbusy;
    logic [BLK-1:0] nb;
    bit             acc, st, dn;

    initial begin
        vecs[0].idx = 32'h76543210; vecs[1].idx = 32'hFEDCBA98; vecs[2].idx = 32'hFFFFFFFF;
        vecs[3].idx = 32'h00000000; vecs[4].idx = 32'h0F1E2D3C; vecs[5].idx = 32'h9A5B3C71;
        foreach (vecs[k]) vecs[k].exp = lookup(seq_blk(0), vecs[k].idx);

        // reset values
        mindex_bus_i = 32'h76543210;
        #2 rst_i = 0;
        #1;
        chk1("rst_ready", m_ready_o, 1'b1);
        chk1("rst_valid", blk_valid_o, 1'b0);
        chk1("rst_last", blk_last_o, 1'b0);
        chk("rst_bus", m_bus_o, '0);
        @(negedge clk); rst_i = 1;

        // single block
        load_words(0, 1, 16);
        chk1("t1_valid", blk_valid_o, 1'b1);
        chk1("t1_last", blk_last_o, 1'b1);
        pulse_start();
        chk1("t1_busy_valid", blk_valid_o, 1'b0);
        foreach (vecs[k]) begin
            mindex_bus_i = vecs[k].idx;
            #1 chk("t1_lookup", m_bus_o, vecs[k].exp);
            @(negedge clk);
        end
        pulse_done();
        chk1("t1_done_valid", blk_valid_o, 1'b0);
        chk1("t1_done_ready", m_ready_o, 1'b1);

        // back-pressure
        load_words(64'h100, 0, 16);
        chk1("t2_ready_a", m_ready_o, 1'b1);
        load_words(64'h200, 1, 16);
        chk1("t2_ready_b", m_ready_o, 1'b0);
        chk1("t2_valid_a", blk_valid_o, 1'b1);
        chk1("t2_last_a", blk_last_o, 1'b0);
        m_valid_i = 1; m_data_i = 64'hDEAD;
        repeat (3) begin @(negedge clk); chk1("t2_held", m_ready_o, 1'b0); end
        m_valid_i = 0;
        mindex_bus_i = 32'h33333333;
        #1 chk("t2_lookup_a", m_bus_o, lookup(seq_blk(64'h100), mindex_bus_i));
        @(negedge clk);
        pulse_start();
        pulse_done();
        chk1("t2_ready_free", m_ready_o, 1'b1);
        chk1("t2_valid_b", blk_valid_o, 1'b1);
        chk1("t2_last_b", blk_last_o, 1'b1);
        chk("t2_lookup_b", m_bus_o, {NR{64'h203}});
        pulse_start();
        pulse_done();
        chk1("t2_empty", blk_valid_o, 1'b0);

        // overlap: load B while A busy, done with B word 15
        load_words(64'h100, 0, 16);
        pulse_start();
        mindex_bus_i = 32'hFFFFFFFF;
        for (int i = 0; i < 15; i++) begin
            word(64'h200 + W'(i), 0);
            chk("t3_hold_a", m_bus_o, {NR{64'h10F}});
        end
        m_valid_i = 1; m_data_i = 64'h20F; m_last_i = 1; blk_done_i = 1;
        @(negedge clk);
        m_valid_i = 0; m_last_i = 0; blk_done_i = 0;
        chk1("t3_valid_b", blk_valid_o, 1'b1);
        chk1("t3_last_b", blk_last_o, 1'b1);
        chk("t3_lookup_b", m_bus_o, {NR{64'h20F}});
        pulse_start();
        pulse_done();

        // ignored strobes
        pulse_done();
        chk1("t4_idle_valid", blk_valid_o, 1'b0);
        chk1("t4_idle_ready", m_ready_o, 1'b1);
        load_words(64'h300, 0, 16);
        pulse_done();
        chk1("t4_done_unstarted", blk_valid_o, 1'b1);
        pulse_start();
        pulse_start();
        chk1("t4_start_busy", blk_valid_o, 1'b0);
        mindex_bus_i = 32'h76543210;
        #1 chk("t4_lookup", m_bus_o, lookup(seq_blk(64'h300), mindex_bus_i));
        @(negedge clk);
        pulse_done();
        chk1("t4_after_valid", blk_valid_o, 1'b0);
        chk1("t4_after_ready", m_ready_o, 1'b1);

        // reset mid-load
        load_words(64'h500, 0, 7);
        rst_i = 0;
        #1;
        chk1("t5_ready", m_ready_o, 1'b1);
        chk1("t5_valid", blk_valid_o, 1'b0);
        chk("t5_bus", m_bus_o, '0);
        @(negedge clk); rst_i = 1;
        load_words(64'h400, 0, 16);
        chk1("t5_fresh_valid", blk_valid_o, 1'b1);
        pulse_start();
        chk("t5_lookup", m_bus_o, lookup(seq_blk(64'h400), mindex_bus_i));
        pulse_done();

        // flush while busy with both banks full, then partial load discarded by a second flush
        load_words(64'h600, 1, 16);
        load_words(64'h700, 0, 16);
        pulse_start();
        chk1("t6_full", m_ready_o, 1'b0);
        flush_i = 1; @(negedge clk); flush_i = 0;
        chk1("t6_valid", blk_valid_o, 1'b0);
        chk1("t6_ready", m_ready_o, 1'b1);
        chk1("t6_last", blk_last_o, 1'b0);
        chk("t6_bus", m_bus_o, '0);
        load_words(64'h900, 0, 3);
        flush_i = 1; @(negedge clk); flush_i = 0;
        load_words(64'h800, 1, 16);
        chk1("t6_reload_valid", blk_valid_o, 1'b1);
        chk1("t6_reload_last", blk_last_o, 1'b1);
        pulse_start();
        chk("t6_lookup0", m_bus_o, lookup(seq_blk(64'h800), mindex_bus_i));
        mindex_bus_i = 32'hFEDCBA98;
        #1 chk("t6_lookup1", m_bus_o, lookup(seq_blk(64'h800), mindex_bus_i));
        @(negedge clk);

        // randomized run against a block-queue model
        flush_i = 1; @(negedge clk); flush_i = 0;
        mbusy = 0;
        repeat (3000) begin
            m_valid_i    = 1'($urandom_range(0, 1));
            m_data_i     = {$urandom, $urandom};
            m_last_i     = 1'($urandom_range(0, 1));
            blk_start_i  = ($urandom_range(0, 3) == 0);
            blk_done_i   = ($urandom_range(0, 3) == 0);
            flush_i      = ($urandom_range(0, 127) == 0);
            mindex_bus_i = $urandom;
            #1;
            chk1("rnd_ready", m_ready_o, qw.size() < 2);
            chk1("rnd_valid", blk_valid_o, qw.size() != 0 && !mbusy);
            if (qw.size() != 0) begin
                chk1("rnd_last", blk_last_o, ql[0]);
                chk("rnd_bus", m_bus_o, lookup(qw[0], mindex_bus_i));
            end
            @(posedge clk);
            if (flush_i) begin
                qw.delete(); ql.delete(); part.delete(); mbusy = 0;
            end else begin
                acc = m_valid_i && qw.size() < 2;
                st  = blk_start_i && qw.size() != 0 && !mbusy;
                dn  = blk_done_i && mbusy;
                if (dn) begin void'(qw.pop_front()); void'(ql.pop_front()); mbusy = 0; end
                if (st) mbusy = 1;
                if (acc) begin
                    part.push_back(m_data_i);
                    if (part.size() == 16) begin
                        for (int i = 0; i < 16; i++) nb[i*W +: W] = part[i];
                        qw.push_back(nb);
                        ql.push_back(m_last_i);
                        part.delete();
                    end
                end
            end
            @(negedge clk);
        end
        m_valid_i = 0; blk_start_i = 0; blk_done_i = 0; flush_i = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
